// File: rtl/approx_resp_monitor.sv
// Approximate-circuit response monitor.
// Accumulates error metrics over one exhaustive 2^NI-vector run.
module approx_resp_monitor #(
    parameter int NI   = 7,
    parameter int NO   = 4,
    parameter int HD_W = NI + $clog2(NO + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NO-1:0]    po_exact,
    input  logic [NO-1:0]    po_apx,
    output logic             busy,
    output logic             done,
    output logic [NI:0]      vec_idx,
    output logic [NI:0]      err_count,
    output logic [HD_W-1:0]  hd_sum,
    output logic [NI+NO-1:0] abs_err_sum,
    output logic [NO-1:0]    max_abs_err
);

    localparam int HW = $clog2(NO + 1);
    localparam logic [NI:0] LAST_IDX = {1'b0, {NI{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic          accept;
    logic          last_acc;
    logic          clr;
    logic          drain_cnt;
    logic [NO-1:0] x_c;
    logic [HW-1:0] hd_c;
    logic [NO:0]   d_c;
    logic [NO:0]   mag_c;
    logic [NO-1:0] diff_c;

    logic          s1_vld;
    logic [NO-1:0] s1_diff;
    logic [HW-1:0] s1_hd;
    logic          s1_mis;

    assign accept   = in_valid & in_ready;
    assign last_acc = accept && (vec_idx == LAST_IDX);
    assign clr      = start && ((state == IDLE) || (state == DONE));
    assign busy     = (state == RUN) || (state == DRAIN);

    // Next-state logic: run until the final accept, then drain the pipeline
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_acc) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus registered handshake/status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            done      <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == RUN);
            done      <= (state_nxt == DONE);
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Per-sample error terms: xor popcount and unsigned absolute difference
    always_comb begin
        x_c  = po_exact ^ po_apx;
        hd_c = '0;
        for (int i = 0; i < NO; i++) begin
            hd_c = hd_c + HW'(x_c[i]);
        end
        d_c    = {1'b0, po_exact} - {1'b0, po_apx};
        mag_c  = d_c[NO] ? (~d_c + 1'b1) : d_c;
        diff_c = mag_c[NO-1:0];
    end

    // Sample counter, cleared when a run starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx <= '0;
        end else if (clr) begin
            vec_idx <= '0;
        end else if (accept) begin
            vec_idx <= vec_idx + 1'b1;
        end
    end

    // Stage 1: register the error terms of each accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_diff <= '0;
            s1_hd   <= '0;
            s1_mis  <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_diff <= diff_c;
                s1_hd   <= hd_c;
                s1_mis  <= (x_c != '0);
            end
        end
    end

    // Stage 2: fold stage-1 terms into the run accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count   <= '0;
            hd_sum      <= '0;
            abs_err_sum <= '0;
            max_abs_err <= '0;
        end else if (clr) begin
            err_count   <= '0;
            hd_sum      <= '0;
            abs_err_sum <= '0;
            max_abs_err <= '0;
        end else if (s1_vld) begin
            err_count   <= err_count + (NI+1)'(s1_mis);
            hd_sum      <= hd_sum + HD_W'(s1_hd);
            abs_err_sum <= abs_err_sum + (NI+NO)'(s1_diff);
            if (s1_diff > max_abs_err) begin
                max_abs_err <= s1_diff;
            end
        end
    end

endmodule

// File: tb/tb_approx_resp_monitor.sv
// Bench for approx_resp_monitor: random runs against a queue-based
// model, scoreboard compared when done rises.
module tb_approx_resp_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  po_exact = '0;
    logic [3:0]  po_apx = '0;
    logic        busy;
    logic        done;
    logic [7:0]  vec_idx;
    logic [7:0]  err_count;
    logic [9:0]  hd_sum;
    logic [10:0] abs_err_sum;
    logic [3:0]  max_abs_err;

    approx_resp_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .po_exact   (po_exact),
        .po_apx     (po_apx),
        .busy       (busy),
        .done       (done),
        .vec_idx    (vec_idx),
        .err_count  (err_count),
        .hd_sum     (hd_sum),
        .abs_err_sum(abs_err_sum),
        .max_abs_err(max_abs_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int vec;
        int err;
        int hd;
        int abs_s;
        int mx;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    logic done_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: on each rising done, pop the expected metrics and compare
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no result");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("vec_idx", int'(vec_idx), e.vec);
                chk("err_count", int'(err_count), e.err);
                chk("hd_sum", int'(hd_sum), e.hd);
                chk("abs_err_sum", int'(abs_err_sum), e.abs_s);
                chk("max_abs_err", int'(max_abs_err), e.mx);
                chk("done_latency", cyc - last_acc_cyc, 3);
            end
        end
        done_d = done;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_vec_idx"}, int'(vec_idx), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_hd_sum"}, int'(hd_sum), 0);
        chk({tag, "_abs_err_sum"}, int'(abs_err_sum), 0);
        chk({tag, "_max_abs_err"}, int'(max_abs_err), 0);
    endtask

    // mode 1: apx==exact, 2: apx=exact^1, 3: single 0xF/0x0 miss on vector 127
    task automatic run(input int mode, input bit gaps, input int abort_at,
                       input int mid_start, input int extra);
        logic [3:0] eq[$];
        logic [3:0] aq[$];
        logic [3:0] e;
        logic [3:0] a;
        bit         v;
        bit         mid_done;
        bit         mid_chk;
        int         acc;
        int         guard;
        exp_t       x;
        acc = 0;
        guard = 0;
        mid_done = 0;
        mid_chk = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ready_after_start", int'(in_ready), 1);
        chk("busy_after_start", int'(busy), 1);
        chk("done_after_start", int'(done), 0);
        chk("err_cleared_at_start", int'(err_count), 0);
        while (acc < 128 && guard < 3000) begin
            guard++;
            if (guard > 1) @(negedge clk);
            start = 1'b0;
            if (mid_chk) begin
                chk("vec_idx_mid_start", int'(vec_idx), acc);
                mid_chk = 0;
            end
            if (abort_at > 0 && acc == abort_at) begin
                in_valid = 1'b0;
                chk("vec_idx_before_abort", int'(vec_idx), abort_at);
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            e = 4'($urandom_range(0, 15));
            a = e;
            if (mode == 2) a = e ^ 4'b0001;
            if (mode == 3 && acc == 127) begin
                e = 4'hF;
                a = 4'h0;
            end
            if (v) begin
                in_valid = 1'b1;
                po_exact = e;
                po_apx   = a;
            end else begin
                in_valid = 1'b0;
                po_exact = 4'($urandom_range(0, 15));
                po_apx   = ~po_exact;
            end
            if (mid_start >= 0 && acc == mid_start && !mid_done) begin
                start = 1'b1;
                mid_done = 1;
                mid_chk = 1;
            end
            if (v && in_ready) begin
                eq.push_back(e);
                aq.push_back(a);
                acc++;
                last_acc_cyc = cyc;
            end
        end
        if (acc < 128) begin
            chk("accept_timeout", acc, 128);
            in_valid = 1'b0;
            return;
        end
        x.vec = 128;
        x.err = 0;
        x.hd = 0;
        x.abs_s = 0;
        x.mx = 0;
        foreach (eq[i]) begin
            int d;
            d = int'(eq[i]) - int'(aq[i]);
            if (d < 0) d = -d;
            if (eq[i] != aq[i]) x.err++;
            x.hd += $countones(eq[i] ^ aq[i]);
            x.abs_s += d;
            if (d > x.mx) x.mx = d;
        end
        sb_q.push_back(x);
        @(negedge clk);
        in_valid = (extra > 0);
        chk("ready_low_after_last", int'(in_ready), 0);
        for (int i = 0; i < extra; i++) begin
            po_exact = 4'($urandom_range(0, 15));
            po_apx   = ~po_exact;
            @(negedge clk);
            chk("no_over_accept", int'(vec_idx), 128);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        if (!done) chk("done_timeout", int'(done), 1);
        @(negedge clk);
        chk("busy_in_done", int'(busy), 0);
        chk("done_held", int'(done), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(1, 0, 0, -1, 0);
        run(2, 0, 0, -1, 0);
        run(3, 0, 0, -1, 0);
        run(2, 1, 0, -1, 3);
        run(1, 0, 50, -1, 0);
        run(1, 0, 0, -1, 0);
        run(2, 1, 0, -1, 0);
        run(1, 1, 0, 60, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
